frame_wr_sched: RTL

Write-port scheduler for the dual-port frame buffer RAM (addr_in/data_in/regwrite side). It sequences full-buffer clears and camera-frame captures, and shares the remaining write slots with a host write port. The read port (VGA side) is untouched. Sits between the camera pixel stream, the host/control logic, and the frame buffer's write port.

---
 rtl/frame_wr_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/frame_wr_sched.sv
// Frame buffer write-port scheduler.
// Sequences full-buffer clears and camera frame captures onto the buffer's
// single write port. Leftover write slots go to a host write port. All
// outputs are registered: a write decided at edge t is presented in cycle t+1.
module frame_wr_sched #(
  parameter int AW   = 13,
  parameter int DW   = 3,
  parameter int NPIX = 4800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  input  logic [DW-1:0] fill_data,
  input  logic          cap_req,
  input  logic          cont,
  input  logic          stop_req,
  input  logic          frame_start,
  input  logic          px_valid,
  input  logic [DW-1:0] px_data,
  input  logic          hw_req,
  input  logic [AW-1:0] hw_addr,
  input  logic [DW-1:0] hw_data,
  output logic          hw_ack,
  input  logic          err_clr,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          busy,
  output logic          done,
  output logic          overflow,
  output logic          short_frame,
  output logic          addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ARM, S_CAP} state_t;

  localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);
  localparam logic [AW:0]   NPIX_X = (AW + 1)'(NPIX);

  state_t        r_state, w_nstate;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic          r_cont, w_cont_nxt;
  logic [DW-1:0] r_fill;

  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_we, r_done, r_hw_ack, r_busy;
  logic          r_ovf, r_short, r_aerr;

  // Shared decode of the current cycle's write decision
  logic [AW-1:0] w_base;
  logic          w_in_cap, w_clr_wr, w_pix_wr, w_pix_last, w_clr_last;
  logic          w_grant, w_haddr_ok;
  logic          w_we, w_done, w_set_ovf, w_set_short, w_set_aerr;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  // A frame_start in CAPTURE restarts the pixel address at 0 for this cycle
  assign w_in_cap   = (r_state == S_CAP);
  assign w_base     = (w_in_cap && frame_start) ? '0 : r_cnt;
  assign w_clr_wr   = (r_state == S_CLEAR);
  assign w_clr_last = w_clr_wr && (r_cnt == LAST);
  assign w_pix_wr   = w_in_cap && px_valid && ({1'b0, w_base} < NPIX_X);
  assign w_pix_last = w_pix_wr && (w_base == LAST);
  assign w_haddr_ok = ({1'b0, hw_addr} < NPIX_X);
  // Host only gets slots nobody else uses; the registered ack blocks a
  // second grant while the requester is still seeing its acknowledge.
  assign w_grant    = hw_req && !r_hw_ack &&
                      ((r_state == S_IDLE) || (r_state == S_ARM) ||
                       (w_in_cap && !px_valid));

  // State, counter, continuous latch and fill colour registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cont  <= 1'b0;
      r_fill  <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_cnt_nxt;
      r_cont  <= w_cont_nxt;
      if (r_state == S_IDLE && clr_req) r_fill <= fill_data;
    end
  end

  // Next-state, counter and continuous-mode decisions
  always_comb begin
    w_nstate   = r_state;
    w_cnt_nxt  = r_cnt;
    w_cont_nxt = r_cont;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_nstate  = S_CLEAR;
          w_cnt_nxt = '0;
        end else if (cap_req) begin
          w_nstate   = S_ARM;
          w_cont_nxt = cont;
        end
      end
      S_CLEAR: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (w_clr_last) begin
          w_nstate  = S_IDLE;
          w_cnt_nxt = '0;
        end
      end
      S_ARM: begin
        if (stop_req) begin
          w_nstate   = S_IDLE;
          w_cont_nxt = 1'b0;
        end else if (frame_start) begin
          w_nstate  = S_CAP;
          w_cnt_nxt = '0;
        end
      end
      S_CAP: begin
        if (stop_req) w_cont_nxt = 1'b0;
        if (frame_start) w_cnt_nxt = '0;
        if (w_pix_wr) begin
          w_cnt_nxt = w_base + AW'(1);
          if (w_pix_last) begin
            w_nstate  = (r_cont && !stop_req) ? S_ARM : S_IDLE;
            w_cnt_nxt = '0;
          end
        end
      end
      default: begin
        w_nstate  = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // Write-port selection and status events for this cycle
  always_comb begin
    w_we        = 1'b0;
    w_addr      = r_addr;
    w_data      = r_data;
    w_done      = w_clr_last || w_pix_last;
    w_set_ovf   = w_in_cap && px_valid && !w_pix_wr;
    w_set_short = w_in_cap && frame_start && ({1'b0, r_cnt} < NPIX_X);
    w_set_aerr  = w_grant && !w_haddr_ok;
    if (w_clr_wr) begin
      w_we   = 1'b1;
      w_addr = r_cnt;
      w_data = r_fill;
    end else if (w_pix_wr) begin
      w_we   = 1'b1;
      w_addr = w_base;
      w_data = px_data;
    end else if (w_grant && w_haddr_ok) begin
      w_we   = 1'b1;
      w_addr = hw_addr;
      w_data = hw_data;
    end
  end

  // Output registers; sticky flags favour a set over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_done   <= 1'b0;
      r_hw_ack <= 1'b0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
      r_short  <= 1'b0;
      r_aerr   <= 1'b0;
    end else begin
      r_addr   <= w_addr;
      r_data   <= w_data;
      r_we     <= w_we;
      r_done   <= w_done;
      r_hw_ack <= w_grant;
      r_busy   <= (w_nstate != S_IDLE);
      r_ovf    <= w_set_ovf   ? 1'b1 : (err_clr ? 1'b0 : r_ovf);
      r_short  <= w_set_short ? 1'b1 : (err_clr ? 1'b0 : r_short);
      r_aerr   <= w_set_aerr  ? 1'b1 : (err_clr ? 1'b0 : r_aerr);
    end
  end

  assign addr_in     = r_addr;
  assign data_in     = r_data;
  assign regwrite    = r_we;
  assign done        = r_done;
  assign hw_ack      = r_hw_ack;
  assign busy        = r_busy;
  assign overflow    = r_ovf;
  assign short_frame = r_short;
  assign addr_err    = r_aerr;

endmodule
